seq_div_16x8: RTL and testbench
===============================

# seq_div_16x8

Sequential restoring divider, 16-bit dividend by 8-bit divisor, producing an 8-bit quotient and 8-bit remainder. It is the inverse datapath for the team's 8x8 approximate multipliers. It recovers an operand from a 16-bit product, and the verification flow uses it to measure multiplier error (product / b vs. a). Operands are accepted and results returned through independent valid/ready handshakes, and the block computes one quotient bit per cycle.

## Interface
Parameters:
- `DW`, 8: divisor/quotient/remainder width; dividend is 2*DW. Only 8 is verified.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  dividend/divisor presented.
- `in_ready`  out  1  block can accept operands.
- `dividend`  in  16  numerator, typically a multiplier `prod8`.
- `divisor`  in  8  denominator.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `quot`  out  8  quotient.
- `rem`  out  8  remainder.
- `err`  out  1  divide-by-zero or quotient overflow.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1.
  - The accept condition is `in_valid && in_ready`.
  - Operands are registered on that edge. Operands are ignored when not accepted.
- Error check at accept:
  - Error if `divisor==0` or `dividend[15:8] >= divisor`.
  - On error, go to DONE with `quot`=8'hFF, `rem`=8'h00, `err`=1.
  - Otherwise go to CALC with the partial remainder set to `dividend[15:8]` and the iteration counter at 0.
- CALC, one iteration per cycle, processing dividend bits 7 down to 0:
  - t = {pr, next dividend bit}, 9 bits.
  - If t >= divisor: pr = t - divisor and the quotient bit is 1.
  - Otherwise: pr = t[7:0] and the quotient bit is 0.
  - The quotient bit shifts into `quot` at the LSB.
  - pr < divisor always holds, so 8 bits suffice.
- CALC ends after ITER iterations (8, or 6 per Configuration), then the block enters DONE.
- DONE:
  - `out_valid`=1; `quot`, `rem` and `err` are stable.
  - On `out_valid && out_ready`, go to IDLE.
  - `in_ready` stays 0 until IDLE is reached, so results are never overwritten.
- Outputs `quot`, `rem` and `err` are valid only while `out_valid`=1.
  - Outside DONE they hold the last result, or reset values.
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE, `in_ready`=1 after the edge, `out_valid`=0, `quot`=0, `rem`=0, `err`=0, counter=0.
  - Reset mid-CALC or mid-DONE aborts the operation and discards the result. No partial result is emitted.

## Timing
- Non-error path:
  - Accept edge T.
  - CALC iterations occur on edges T+1 … T+ITER.
  - `out_valid` is high in the cycle after edge T+ITER.
  - Latency is ITER edges from accept to visible result.
- Error path: `out_valid` is high after edge T+1.
- If `out_ready`=1 while `out_valid`=1, the handshake completes on that edge.
  - `in_ready` is high on the next cycle.
  - Throughput is one operation per ITER+2 cycles with no backpressure.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid`/`out_ready`.
- `out_ready` held low keeps DONE indefinitely, with all outputs constant.

## Configuration
- Macro `APPROX_DIV_TRUNC_EN`.
- Undefined: ITER=8, exact restoring division.
- Defined:
  - ITER=6, processing dividend bits 7..2 only.
  - `quot` = {6 computed bits, 2'b00}.
  - `rem` = pr after 6 iterations, i.e. the remainder of dividend[15:2] / divisor.
  - The error check is unchanged.
  - Latency is 6.

## Structure
- Package `div_pkg`:
  - state enum (IDLE, CALC, DONE).
  - `DIV_DW`=8.
  - `DIV_ITER` (8, or 6 under the macro).
  - error constants `QUOT_ERR`=8'hFF and `REM_ERR`=8'h00.
- Sub-module `div_step`:
  - Combinational, one restoring iteration.
  - Inputs: pr[7:0], dividend bit, divisor[7:0].
  - Outputs: pr_next[7:0], qbit.
  - Instantiated once and reused each cycle.

## Test plan
- Exact product: dividend 16'h4E20 (100*200), divisor 200 → `quot`=100, `rem`=0, `err`=0, `out_valid` 8 cycles after accept.
- Non-zero remainder: 16'h4E2A, divisor 200 → `quot`=100, `rem`=10. Under `APPROX_DIV_TRUNC_EN`: `quot`=100, `rem`=2, latency 6.
- Errors:
  - divisor 0 → `quot`=8'hFF, `rem`=0, `err`=1, `out_valid` 1 cycle after accept.
  - dividend 16'hC800, divisor 200 → same error response.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs constant, `in_ready`=0. A new `in_valid` in that window is not accepted.
- Reset mid-CALC: assert `rst_n`=0 at the 4th iteration → next cycle IDLE, `out_valid`=0, all outputs 0. The following operation (255*255=16'hFE01 / 255) → `quot`=255, `rem`=0.
- Back-to-back: `in_valid` held high with `out_ready`=1 and three operand sets → three results in order, each accept exactly ITER+2 cycles apart.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the 16x8 sequential divider (APPROX_DIV_TRUNC_EN selects 6 iterations)
package div_pkg;

  localparam int DIV_DW = 8;

`ifdef APPROX_DIV_TRUNC_EN
  localparam int DIV_ITER = 6;
`else
  localparam int DIV_ITER = 8;
`endif

  localparam logic [DIV_DW-1:0] QUOT_ERR = 8'hFF;
  localparam logic [DIV_DW-1:0] REM_ERR  = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
  import div_pkg::*;
(
  input  logic [DIV_DW-1:0] pr,
  input  logic              dbit,
  input  logic [DIV_DW-1:0] divisor,
  output logic [DIV_DW-1:0] pr_next,
  output logic              qbit
);

  logic [DIV_DW:0] t;
  logic [DIV_DW:0] diff;

  // Shift the next dividend bit into the partial remainder and restore on underflow
  always_comb begin
    t       = {pr, dbit};
    diff    = t - {1'b0, divisor};
    qbit    = (t >= {1'b0, divisor});
    pr_next = qbit ? diff[DIV_DW-1:0] : t[DIV_DW-1:0];
  end

endmodule

// File: rtl/seq_div_16x8.sv
// rtl/seq_div_16x8.sv - sequential restoring divider 16/8 with valid/ready handshakes (APPROX_DIV_TRUNC_EN truncates to 6 quotient bits)
module seq_div_16x8
  import div_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quot,
  output logic [DW-1:0]   rem,
  output logic            err
);

  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_e state_q, state_d;

  logic [DW-1:0]    pr_q;
  logic [DW-1:0]    dvd_q;
  logic [DW-1:0]    dsr_q;
  logic [DW-1:0]    q_sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_pend_q;
  logic [DW-1:0]    quot_q;
  logic [DW-1:0]    rem_q;
  logic             err_q;

  logic [DW-1:0] pr_next;
  logic          qbit;
  logic [DW-1:0] q_next;
  logic [DW-1:0] q_final;
  logic          op_err;
  logic          last;

  assign quot = quot_q;
  assign rem  = rem_q;
  assign err  = err_q;

  assign op_err = (divisor == '0) || (dividend[2*DW-1:DW] >= divisor);
  // An erroneous operation spends a single cycle in CALC so its result shows one cycle after accept
  assign last   = err_pend_q || (cnt_q == CNT_LAST);
  assign q_next = {q_sh_q[DW-2:0], qbit};

`ifdef APPROX_DIV_TRUNC_EN
  assign q_final = {q_next[DIV_ITER-1:0], {(DW-DIV_ITER){1'b0}}};
`else
  assign q_final = q_next;
`endif

  div_step u_step (
    .pr      (pr_q),
    .dbit    (dvd_q[DW-1]),
    .divisor (dsr_q),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake decodes (pure state decodes, no input feed-through)
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, one quotient bit per CALC cycle, result load on the last iteration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr_q       <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      q_sh_q     <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pr_q       <= dividend[2*DW-1:DW];
            dvd_q      <= dividend[DW-1:0];
            dsr_q      <= divisor;
            q_sh_q     <= '0;
            cnt_q      <= '0;
            err_pend_q <= op_err;
          end
        end
        CALC: begin
          pr_q   <= pr_next;
          dvd_q  <= {dvd_q[DW-2:0], 1'b0};
          q_sh_q <= q_next;
          cnt_q  <= cnt_q + 1'b1;
          if (last) begin
            if (err_pend_q) begin
              quot_q <= QUOT_ERR;
              rem_q  <= REM_ERR;
              err_q  <= 1'b1;
            end else begin
              quot_q <= q_final;
              rem_q  <= pr_next;
              err_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16x8.sv
// tb/tb_seq_div_16x8.sv - scoreboard bench for seq_div_16x8 (APPROX_DIV_TRUNC_EN selects truncated expectations)
module tb_seq_div_16x8;

`ifdef APPROX_DIV_TRUNC_EN
  localparam int ITER = 6;
  localparam logic [7:0] R_4E2A = 8'd2;
  localparam logic [7:0] Q_FE01 = 8'd252, R_FE01 = 8'd191;
  localparam logic [7:0] Q_1234 = 8'd52,  R_1234 = 8'd47;
  localparam logic [7:0] Q_0007 = 8'd0,   R_0007 = 8'd1;
  localparam logic [7:0] Q_7FFF = 8'd252, R_7FFF = 8'd127;
`else
  localparam int ITER = 8;
  localparam logic [7:0] R_4E2A = 8'd10;
  localparam logic [7:0] Q_FE01 = 8'd255, R_FE01 = 8'd0;
  localparam logic [7:0] Q_1234 = 8'd54,  R_1234 = 8'd16;
  localparam logic [7:0] Q_0007 = 8'd2,   R_0007 = 8'd1;
  localparam logic [7:0] Q_7FFF = 8'd255, R_7FFF = 8'd127;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quot;
  logic [7:0]  rem;
  logic        err;

  exp_t sb[$];
  int   acc_q[$];
  int   acc_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;
  logic [7:0] h_q, h_r;
  logic h_e;

  seq_div_16x8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Accept recorder and result monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      acc_q.push_back(cyc + 1);
      acc_log.push_back(cyc + 1);
    end
    if (rst_n && out_valid) begin
      if (!prev_ov) begin
        if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else if (acc_q.size() == 0) chk("no_accept_seen", 32'd1, 32'd0);
        else chk("latency", cyc - acc_q.pop_front(), sb[0].lat);
      end else begin
        chk("hold_quot", quot, h_q);
        chk("hold_rem", rem, h_r);
        chk("hold_err", err, h_e);
      end
      h_q = quot; h_r = rem; h_e = err;
      if (out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("quot", quot, e.q);
        chk("rem", rem, e.r);
        chk("err", err, e.e);
      end
    end
    prev_ov = rst_n && out_valid;
  end

  task automatic push_exp(input logic [7:0] q, input logic [7:0] r, input logic e, input int lat);
    exp_t x;
    x.q = q; x.r = r; x.e = e; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("timeout_in_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && sb.size() == 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("timeout_idle", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [15:0] dvd, input logic [7:0] dsr,
                       input logic [7:0] q, input logic [7:0] r, input logic e, input int lat);
    @(posedge clk); #1;
    dividend = dvd; divisor = dsr; in_valid = 1'b1;
    push_exp(q, r, e, lat);
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 32'd1);
    chk({tag, "_out_valid"}, out_valid, 32'd0);
    chk({tag, "_quot"}, quot, 32'd0);
    chk({tag, "_rem"}, rem, 32'd0);
    chk({tag, "_err"}, err, 32'd0);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    do_op(16'h4E20, 8'd200, 8'd100, 8'd0, 1'b0, ITER);
    do_op(16'h4E2A, 8'd200, 8'd100, R_4E2A, 1'b0, ITER);
    do_op(16'h1234, 8'd0, 8'hFF, 8'h00, 1'b1, 1);
    do_op(16'hC800, 8'd200, 8'hFF, 8'h00, 1'b1, 1);

    // Backpressure: hold out_ready low with a competing in_valid
    out_ready = 1'b0;
    @(posedge clk); #1;
    dividend = 16'h1234; divisor = 8'h56; in_valid = 1'b1;
    push_exp(Q_1234, R_1234, 1'b0, ITER);
    wait_ready();
    @(posedge clk); #1;
    dividend = 16'h0007; divisor = 8'd3;
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    base = acc_log.size();
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 32'd0);
      chk("bp_out_valid", out_valid, 32'd1);
    end
    in_valid = 1'b0;
    chk("bp_no_accept", acc_log.size(), base);
    out_ready = 1'b1;
    wait_idle();

    // Reset during the fourth iteration discards the operation
    @(posedge clk); #1;
    dividend = 16'h4E20; divisor = 8'd200; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    acc_q.delete();
    chk_reset_state("mid_reset");
    rst_n = 1'b1;
    do_op(16'hFE01, 8'd255, Q_FE01, R_FE01, 1'b0, ITER);

    // Back-to-back with in_valid held high
    base = acc_log.size();
    push_exp(Q_1234, R_1234, 1'b0, ITER);
    push_exp(Q_0007, R_0007, 1'b0, ITER);
    push_exp(Q_7FFF, R_7FFF, 1'b0, ITER);
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin dividend = 16'h1234; divisor = 8'h56; end
        1: begin dividend = 16'h0007; divisor = 8'd3; end
        default: begin dividend = 16'h7FFF; divisor = 8'h80; end
      endcase
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_accepts", acc_log.size() - base, 32'd3);
    if (acc_log.size() - base >= 3) begin
      chk("b2b_spacing0", acc_log[base+1] - acc_log[base], ITER + 2);
      chk("b2b_spacing1", acc_log[base+2] - acc_log[base+1], ITER + 2);
    end

    repeat (4) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
